// File: rtl/ibuf_pkg.sv
// Shared types and sizing helpers for the input-buffer stream controller.
package ibuf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } ibuf_state_t;

  // Bits needed to hold any count from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ibuf_ctrl.sv
// Stream-side controller for the CIM input buffer: loads a window, pulses o_start,
// stalls intake until i_done, then slides by stride (or reloads fully after a frame end).
module ibuf_ctrl
  import ibuf_pkg::*;
#(
  parameter int datatype_size = 8,
  parameter int fifo_length   = 720,
  parameter int stride        = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [datatype_size-1:0] s_data,
  input  logic                     s_last,
  output logic                     o_write_enable,
  output logic [datatype_size-1:0] o_data,
  output logic                     o_start,
  input  logic                     i_done,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int CW = cnt_width(fifo_length);
  localparam logic [CW-1:0] FULL_LAST   = CW'(fifo_length - 1);
  localparam logic [CW-1:0] STRIDE_LAST = CW'(stride - 1);

  ibuf_state_t   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          frame_open_q, frame_open_d;
  logic          o_start_q, o_start_d;
  logic          o_busy_q, o_busy_d;
  logic          o_err_q, o_err_d;

  logic          accept;
  logic          complete;
  logic [CW-1:0] last_idx;

  // frame_open means a window of this frame already completed, so the
  // next window only needs stride fresh elements instead of a full load.
  assign last_idx = frame_open_q ? STRIDE_LAST : FULL_LAST;
  assign s_ready  = (state_q == LOAD);
  assign accept   = s_ready & s_valid;
  assign complete = accept & (count_q == last_idx);

  assign o_write_enable = accept;
  assign o_data         = s_data;
  assign o_start        = o_start_q;
  assign o_busy         = o_busy_q;
  assign o_err          = o_err_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    frame_open_d = frame_open_q;
    o_start_d    = 1'b0;
    o_busy_d     = 1'b0;
    o_err_d      = 1'b0;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (complete) begin
          state_d      = START;
          count_d      = '0;
          frame_open_d = ~s_last;
          o_start_d    = 1'b1;
        end else if (accept) begin
          if (s_last) begin
            // Frame ended mid-window: drop the partial window, next one is a full load.
            count_d      = '0;
            frame_open_d = 1'b0;
            o_err_d      = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      START: begin
        state_d  = WAIT;
        o_busy_d = 1'b1;
      end
      WAIT: begin
        if (i_done) state_d  = LOAD;
        else        o_busy_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      frame_open_q <= 1'b0;
      o_start_q    <= 1'b0;
      o_busy_q     <= 1'b0;
      o_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      frame_open_q <= frame_open_d;
      o_start_q    <= o_start_d;
      o_busy_q     <= o_busy_d;
      o_err_q      <= o_err_d;
    end
  end

endmodule

// File: tb/tb_ibuf_ctrl.sv
// Bench for ibuf_ctrl: directed scenarios plus random traffic against a window-level reference model.
module tb_ibuf_ctrl;

  localparam int DW = 8;
  localparam int FL = 4;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          i_done = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, o_write_enable, o_start, o_busy, o_err;
  logic [DW-1:0] o_data;

  ibuf_ctrl #(.datatype_size(DW), .fifo_length(FL), .stride(ST)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .o_write_enable(o_write_enable),
    .o_data(o_data), .o_start(o_start), .i_done(i_done), .o_busy(o_busy),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  int we_cnt = 0;

  // Downstream buffer as the parent would build it (index 0 = newest).
  logic [DW-1:0] tb_buf [FL];
  // Expected window contents, newest first.
  logic [DW-1:0] exp_q [$];

  // Reference model: tracks phase as booleans and fresh-element count per window.
  bit m_idle = 1'b1;
  bit m_loading, m_start, m_busy, m_errp, m_open;
  int m_got;

  always @(posedge clk or negedge rst_n) begin
    bit ns, ne;
    ns = 1'b0;
    ne = 1'b0;
    if (!rst_n) begin
      m_idle = 1'b1; m_loading = 1'b0; m_start = 1'b0; m_busy = 1'b0;
      m_errp = 1'b0; m_open = 1'b0; m_got = 0;
    end else begin
      if (m_idle) begin
        m_idle = 1'b0;
        m_loading = 1'b1;
      end else if (m_loading) begin
        if (s_valid) begin
          exp_q.push_front(s_data);
          if (exp_q.size() > FL) void'(exp_q.pop_back());
          m_got++;
          if (m_got == (m_open ? ST : FL)) begin
            ns = 1'b1; m_loading = 1'b0; m_open = !s_last; m_got = 0;
          end else if (s_last) begin
            ne = 1'b1; m_got = 0; m_open = 1'b0;
          end
        end
      end else if (m_start) begin
        m_busy = 1'b1;
      end else if (m_busy && i_done) begin
        m_busy = 1'b0;
        m_loading = 1'b1;
      end
      m_start = ns;
      m_errp  = ne;
    end
  end

  // Scoreboard: every cycle, compare all outputs against the model at the falling edge.
  always @(negedge clk) begin
    bit exp_we;
    exp_we = m_loading && s_valid;
    n_vec += 5;
    if (s_ready !== m_loading) begin n_err++; $display("FAIL mon_s_ready t=%0t got=%b exp=%b", $time, s_ready, m_loading); end
    if (o_write_enable !== exp_we) begin n_err++; $display("FAIL mon_we t=%0t got=%b exp=%b", $time, o_write_enable, exp_we); end
    if (o_start !== m_start) begin n_err++; $display("FAIL mon_start t=%0t got=%b exp=%b", $time, o_start, m_start); end
    if (o_busy !== m_busy) begin n_err++; $display("FAIL mon_busy t=%0t got=%b exp=%b", $time, o_busy, m_busy); end
    if (o_err !== m_errp) begin n_err++; $display("FAIL mon_err t=%0t got=%b exp=%b", $time, o_err, m_errp); end
    if (exp_we) begin
      n_vec++;
      if (o_data !== s_data) begin n_err++; $display("FAIL mon_data t=%0t got=%h exp=%h", $time, o_data, s_data); end
    end
    if (m_start) begin
      for (int i = 0; i < FL; i++) begin
        n_vec++;
        if (tb_buf[i] !== exp_q[i]) begin
          n_err++; $display("FAIL mon_window[%0d] t=%0t got=%h exp=%h", i, $time, tb_buf[i], exp_q[i]);
        end
      end
    end
    if (o_start) start_cnt++;
    if (o_err) err_cnt++;
    if (o_write_enable) begin
      we_cnt++;
      for (int i = FL - 1; i > 0; i--) tb_buf[i] = tb_buf[i-1];
      tb_buf[0] = o_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] d, input bit last, input bit auto_done);
    bit acc;
    acc = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = last;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = s_ready;
      if (auto_done && o_busy) i_done = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      i_done = 1'b0;
    end
    s_valid = 1'b0; s_last = 1'b0;
    n_vec++;
    if (!acc) begin n_err++; $display("FAIL send_timeout data=%h accepted=%b exp=1", d, acc); end
  endtask

  task automatic idle(input int n, input bit auto_done);
    repeat (n) begin
      @(negedge clk);
      if (auto_done && o_busy) i_done = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      i_done = 1'b0;
    end
  endtask

  task automatic pulse_done();
    @(negedge clk); i_done = 1'b1;
    @(posedge clk); #1; i_done = 1'b0;
  endtask

  function automatic logic [4*DW-1:0] buf_word();
    return {tb_buf[0], tb_buf[1], tb_buf[2], tb_buf[3]};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({s_ready, o_write_enable, o_start, o_busy, o_err} !== 5'b0) begin
      n_err++; $display("FAIL reset_outputs got=%b exp=00000", {s_ready, o_write_enable, o_start, o_busy, o_err});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_idle_ready got=%b exp=0", s_ready); end
    @(posedge clk); #1;
    n_vec++;
    if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_load_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_first_window();
    int s0, w0;
    s0 = start_cnt; w0 = we_cnt;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b0);
    n_vec++;
    if (o_start !== 1'b1) begin n_err++; $display("FAIL first_start got=%b exp=1", o_start); end
    @(posedge clk); #1;
    n_vec += 4;
    if (o_busy !== 1'b1) begin n_err++; $display("FAIL first_busy got=%b exp=1", o_busy); end
    if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL first_start_count got=%0d exp=1", start_cnt - s0); end
    if (we_cnt - w0 !== 4) begin n_err++; $display("FAIL first_we_count got=%0d exp=4", we_cnt - w0); end
    if (buf_word() !== 32'h04030201) begin n_err++; $display("FAIL first_window got=%h exp=04030201", buf_word()); end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (o_busy !== 1'b1) begin n_err++; $display("FAIL first_busy_hold got=%b exp=1", o_busy); end
    pulse_done();
    n_vec++;
    if ({s_ready, o_busy} !== 2'b10) begin n_err++; $display("FAIL first_after_done got=%b exp=10", {s_ready, o_busy}); end
  endtask

  task automatic test_sliding();
    int s0;
    s0 = start_cnt;
    send(8'h05, 1'b0, 1'b0);
    send(8'h06, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_vec += 2;
    if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL slide_start_count got=%0d exp=1", start_cnt - s0); end
    if (buf_word() !== 32'h06050403) begin n_err++; $display("FAIL slide_window got=%h exp=06050403", buf_word()); end
    pulse_done();
  endtask

  task automatic test_frame_boundary();
    int s0;
    s0 = start_cnt;
    send(8'h07, 1'b0, 1'b0);
    send(8'h08, 1'b0, 1'b0);
    send(8'h09, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_vec++;
    if (start_cnt !== s0) begin n_err++; $display("FAIL frame_early_start got=%0d exp=0", start_cnt - s0); end
    send(8'h0A, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_vec += 2;
    if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL frame_start_count got=%0d exp=1", start_cnt - s0); end
    if (buf_word() !== 32'h0A090807) begin n_err++; $display("FAIL frame_window got=%h exp=0a090807", buf_word()); end
    pulse_done();
  endtask

  task automatic test_mid_last();
    int s0, e0;
    s0 = start_cnt; e0 = err_cnt;
    send(8'h11, 1'b0, 1'b0);
    send(8'h12, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_vec += 2;
    if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL midlast_err_count got=%0d exp=1", err_cnt - e0); end
    if (start_cnt !== s0) begin n_err++; $display("FAIL midlast_no_start got=%0d exp=0", start_cnt - s0); end
    for (int i = 3; i <= 5; i++) send(8'h10 + 8'(i), 1'b0, 1'b0);
    n_vec++;
    if (start_cnt !== s0) begin n_err++; $display("FAIL midlast_early_start got=%0d exp=0", start_cnt - s0); end
    send(8'h16, 1'b0, 1'b0);
    // i_done raised during the start cycle must not release WAIT.
    i_done = 1'b1;
    @(posedge clk); #1;
    i_done = 1'b0;
    @(posedge clk); #1;
    n_vec += 4;
    if (o_busy !== 1'b1) begin n_err++; $display("FAIL early_done_busy got=%b exp=1", o_busy); end
    if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL midlast_start_count got=%0d exp=1", start_cnt - s0); end
    if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL midlast_err_once got=%0d exp=1", err_cnt - e0); end
    if (buf_word() !== 32'h16151413) begin n_err++; $display("FAIL midlast_window got=%h exp=16151413", buf_word()); end
  endtask

  task automatic test_wait_hold();
    int bad;
    bad = 0;
    s_valid = 1'b1; s_data = 8'hEE;
    repeat (5) begin
      @(negedge clk);
      if (s_ready !== 1'b0 || o_write_enable !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL wait_hold bad_cycles=%0d exp=0", bad); end
    pulse_done();
  endtask

  task automatic test_random();
    int w0, sent;
    w0 = we_cnt; sent = 0;
    for (int i = 0; i < 60; i++) begin
      idle($urandom_range(0, 3), 1'b1);
      send(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), 1'b1);
      sent++;
    end
    n_vec++;
    if (we_cnt - w0 !== sent) begin n_err++; $display("FAIL random_accept_count got=%0d exp=%0d", we_cnt - w0, sent); end
    idle(8, 1'b1);
  endtask

  task automatic test_async_reset();
    int s0;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    s0 = start_cnt;
    for (int i = 1; i <= 4; i++) send(8'h20 + 8'(i), 1'b0, 1'b0);
    @(posedge clk); #1;
    n_vec++;
    if (o_busy !== 1'b1) begin n_err++; $display("FAIL areset_pre_busy got=%b exp=1", o_busy); end
    s_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({s_ready, o_write_enable, o_start, o_busy, o_err} !== 5'b0) begin
      n_err++; $display("FAIL areset_outputs got=%b exp=00000", {s_ready, o_write_enable, o_start, o_busy, o_err});
    end
    s_valid = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 3; i++) send(8'h30 + 8'(i), 1'b0, 1'b0);
    n_vec++;
    if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL areset_full_reload got=%0d exp=1", start_cnt - s0); end
    send(8'h34, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_vec += 2;
    if (start_cnt - s0 !== 2) begin n_err++; $display("FAIL areset_restart got=%0d exp=2", start_cnt - s0); end
    if (buf_word() !== 32'h34333231) begin n_err++; $display("FAIL areset_window got=%h exp=34333231", buf_word()); end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_sliding();
    test_frame_boundary();
    test_mid_last();
    test_wait_hold();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t exp=finish before timeout", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
